// File: rtl/spi_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_tx_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one SpiOut transmitter
//             between NUM_REQ requesters. Latches the winner's word, issues a
//             one-cycle writeSPI pulse, follows the transfer through the
//             transmitter's chip select and reports completion.
//  Ports    : clock, resetN (sync, active-low)
//             req/reqData   - per-requester request level and word
//             ack/done      - one-cycle accept / completion pulses
//             timeoutErr    - one-cycle watchdog abandon pulse
//             spiData/writeSPI - to SpiOut; spiCsN - from SpiOut
//             busy, grantId - status
//  Options  : define SPI_ARB_TIMEOUT_EN to enable the wait-state watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            timeoutErr,
    output logic [DATA_WIDTH-1:0]         spiData,
    output logic                          writeSPI,
    input  logic                          spiCsN,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grantId
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE       = NUM_REQ'(1);
    localparam logic [c_ID_W-1:0]  c_LAST_INIT = c_ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_END   = 3'd3,
        S_GAP        = 3'd4
    } state_t;

    state_t                 r_state;
    logic [NUM_REQ-1:0]     r_ack;
    logic [NUM_REQ-1:0]     r_done;
    logic                   r_write;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [c_ID_W-1:0]      r_grant;
    logic [c_ID_W-1:0]      r_last;
    logic                   r_busy;
    logic [c_GAP_W-1:0]     r_gap;

    state_t                 w_state_nxt;
    logic [NUM_REQ-1:0]     w_ack_nxt;
    logic [NUM_REQ-1:0]     w_done_nxt;
    logic                   w_write_nxt;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic [c_ID_W-1:0]      w_grant_nxt;
    logic [c_ID_W-1:0]      w_last_nxt;
    logic                   w_busy_nxt;
    logic [c_GAP_W-1:0]     w_gap_nxt;
    logic                   w_finish;
    logic                   w_wdog_hit;

    logic [c_ID_W-1:0]      w_winner;
    logic [DATA_WIDTH-1:0]  w_win_data;
    int                     w_dist;
    int                     w_best;

    // ------------------------------------------------------------------
    // Round-robin pick: each requester's distance from lastGrant+1
    // (modulo NUM_REQ); the requesting one closest to that point wins.
    // The previous winner therefore always sits at the far end.
    // ------------------------------------------------------------------
    always_comb begin
        w_winner   = '0;
        w_win_data = '0;
        w_best     = NUM_REQ;
        w_dist     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_last) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (req[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_winner   = c_ID_W'(i);
                w_win_data = reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
            r_done  <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_last  <= c_LAST_INIT;
            r_busy  <= 1'b0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_done  <= w_done_nxt;
            r_write <= w_write_nxt;
            r_data  <= w_data_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = '0;
        w_done_nxt  = '0;
        w_write_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_gap_nxt   = r_gap;
        w_finish    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // spiCsN high is required so a transfer left running by a
                // reset finishes before spiData is overwritten.
                if ((|req) && spiCsN) begin
                    w_data_nxt  = w_win_data;
                    w_grant_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_ack_nxt   = c_ONE << w_winner;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_write_nxt = 1'b1;
                w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!spiCsN) begin
                    w_state_nxt = S_WAIT_END;
                end else if (w_wdog_hit) begin
                    w_finish = 1'b1;
                end
            end
            S_WAIT_END: begin
                if (spiCsN) begin
                    w_done_nxt = c_ONE << r_grant;
                    w_finish   = 1'b1;
                end else if (w_wdog_hit) begin
                    w_finish = 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_gap_nxt = r_gap - c_GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Common exit from the wait states, normal or abandoned.
        if (w_finish) begin
            if (GAP_CYCLES > 0) begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = c_GAP_W'(GAP_CYCLES - 1);
            end else begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0]  r_wdog;
    logic [NUM_REQ-1:0] r_timeout;

    // Hit only when the state would otherwise stay put, so a chip-select
    // edge arriving on the last allowed cycle still completes normally.
    assign w_wdog_hit = (r_wdog == c_WD_LIMIT) &&
                        (((r_state == S_WAIT_START) && spiCsN) ||
                         ((r_state == S_WAIT_END) && !spiCsN));

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_wdog    <= '0;
            r_timeout <= '0;
        end else begin
            r_timeout <= w_wdog_hit ? (c_ONE << r_grant) : '0;
            if (w_state_nxt != r_state) begin
                r_wdog <= '0;
            end else if ((r_state == S_WAIT_START) || (r_state == S_WAIT_END)) begin
                r_wdog <= r_wdog + c_WD_W'(1);
            end
        end
    end

    assign timeoutErr = r_timeout;
`else
    assign w_wdog_hit = 1'b0;
    assign timeoutErr = '0;
`endif

    assign ack      = r_ack;
    assign done     = r_done;
    assign writeSPI = r_write;
    assign spiData  = r_data;
    assign grantId  = r_grant;
    assign busy     = r_busy;

endmodule
`default_nettype wire
